// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: control codes, FSM states and stall-pattern helper
package pipe_hazard_ctrl_pkg;
    localparam int CTRL_W = 2;

    typedef enum logic [CTRL_W-1:0] {
        CTRL_NORMAL  = 2'b00,
        CTRL_STALLED = 2'b01,
        CTRL_FLUSH   = 2'b10
    } ctrl_e;

    typedef enum logic {ST_RUN = 1'b0, ST_DRAIN = 1'b1} state_e;

    // index 0 = PC, 1 = IF_ID, 2 = ID_EX, 3 = EX_MEM, 4 = MEM_WB
    typedef logic [4:0][CTRL_W-1:0] ctrl_vec_t;

    // applied redirect: PC loads the target, the two wrong-path registers take bubbles
    localparam ctrl_vec_t REDIR_VEC = 10'b00_00_10_10_00;

    // k registers hold, register k takes a bubble, the rest load; k=0 means no stall
    function automatic ctrl_vec_t stall_at(input int k);
        ctrl_vec_t v;
        for (int i = 0; i < 5; i++)
            v[i] = (k == 0) ? CTRL_NORMAL : (i < k) ? CTRL_STALLED : (i == k) ? CTRL_FLUSH : CTRL_NORMAL;
        return v;
    endfunction
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: stall/redirect/fence requests in, pipeline register controls out
interface pipe_hazard_ctrl_if #(parameter int ADDR_W = 64);
    import pipe_hazard_ctrl_pkg::*;
    logic              if_stall_req;
    logic              id_stall_req;
    logic              ex_stall_req;
    logic              mem_stall_req;
    logic              ex_redirect_req;
    logic [ADDR_W-1:0] ex_redirect_pc;
    logic              fence_req;
    logic [CTRL_W-1:0] ctrl_pc_o;
    logic [CTRL_W-1:0] ctrl_if_id_o;
    logic [CTRL_W-1:0] ctrl_id_ex_o;
    logic [CTRL_W-1:0] ctrl_ex_mem_o;
    logic [CTRL_W-1:0] ctrl_mem_wb_o;
    logic              redirect_valid_o;
    logic [ADDR_W-1:0] redirect_pc_o;
    logic              drain_done_o;
    logic              stall_timeout_o;

    modport master (
        output if_stall_req, id_stall_req, ex_stall_req, mem_stall_req,
               ex_redirect_req, ex_redirect_pc, fence_req,
        input  ctrl_pc_o, ctrl_if_id_o, ctrl_id_ex_o, ctrl_ex_mem_o, ctrl_mem_wb_o,
               redirect_valid_o, redirect_pc_o, drain_done_o, stall_timeout_o
    );

    modport slave (
        input  if_stall_req, id_stall_req, ex_stall_req, mem_stall_req,
               ex_redirect_req, ex_redirect_pc, fence_req,
        output ctrl_pc_o, ctrl_if_id_o, ctrl_id_ex_o, ctrl_ex_mem_o, ctrl_mem_wb_o,
               redirect_valid_o, redirect_pc_o, drain_done_o, stall_timeout_o
    );
endinterface

// File: rtl/pipe_hazard_ctrl_stall_watchdog.sv
// stall_watchdog: saturating count of consecutive PC-stall cycles, fires at TIMEOUT
module stall_watchdog #(
    parameter int TIMEOUT = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic i_stall,
    output logic o_timeout
);
    localparam int W = $clog2(TIMEOUT + 1);

    logic [W-1:0] r_cnt;

    // count while stalled, hold at TIMEOUT, clear as soon as the PC moves
    always_ff @(posedge clk or posedge rst)
        if (rst)
            r_cnt <= '0;
        else
            r_cnt <= !i_stall ? '0 : (r_cnt == W'(TIMEOUT)) ? r_cnt : r_cnt + 1'b1;

    assign o_timeout = (r_cnt == W'(TIMEOUT));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: per-register pipeline controls, redirect sequencing, fence drain, watchdog
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int ADDR_W    = 64,
    parameter int DRAIN_CYC = 3,
    parameter int TIMEOUT   = 1023
) (
    input  logic            clk,
    input  logic            rst,
    pipe_hazard_ctrl_if.slave bus
);
    localparam int DW = $clog2(DRAIN_CYC + 1);

    state_e            r_state, w_next;
    logic              r_pend;
    logic [ADDR_W-1:0] r_pend_pc;
    logic [DW-1:0]     r_dcnt;
    ctrl_vec_t         w_ctrl;
    logic              w_live, w_blk, w_apply, w_drain, w_clean, w_done, w_timeout;
    logic [ADDR_W-1:0] w_tgt;

    // a pending redirect owns the target; new requests are ignored until it applies
    assign w_live  = bus.ex_redirect_req | r_pend;
    assign w_tgt   = r_pend ? r_pend_pc : bus.ex_redirect_pc;
    assign w_blk   = bus.mem_stall_req | bus.ex_stall_req;
    assign w_apply = w_live & ~w_blk;
    assign w_drain = (r_state == ST_DRAIN);
    assign w_clean = w_drain & ~w_blk & ~w_live;
    assign w_done  = w_clean & (r_dcnt == DW'(DRAIN_CYC - 1));

    // controls: redirect first, then oldest stall; drain looks like an ID stall
    always_comb begin
        w_ctrl = '0;
        if (!rst)
            w_ctrl = w_apply ? REDIR_VEC :
                     bus.mem_stall_req ? stall_at(4) :
                     bus.ex_stall_req ? stall_at(3) :
                     (w_drain | bus.id_stall_req) ? stall_at(2) :
                     bus.if_stall_req ? stall_at(1) : stall_at(0);
    end

    // RUN/DRAIN next state: enter on a clean fence, leave on completion or redirect
    always_comb begin
        w_next = r_state;
        if (!w_drain && bus.fence_req && !w_live && !bus.id_stall_req && !w_blk)
            w_next = ST_DRAIN;
        if (w_drain && (w_apply || w_done))
            w_next = ST_RUN;
    end

    // state register and drain counter; counter only advances on unstalled drain cycles
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_state <= ST_RUN;
            r_dcnt  <= '0;
        end else begin
            r_state <= w_next;
            r_dcnt  <= (w_drain && w_next == ST_DRAIN) ? r_dcnt + DW'(w_clean) : '0;
        end

    // capture a blocked redirect once, release it when it finally applies
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_pend    <= 1'b0;
            r_pend_pc <= '0;
        end else if (w_apply) begin
            r_pend <= 1'b0;
        end else if (w_live && !r_pend) begin
            r_pend    <= 1'b1;
            r_pend_pc <= bus.ex_redirect_pc;
        end

    stall_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
        .clk       (clk),
        .rst       (rst),
        .i_stall   (w_ctrl[0] == CTRL_STALLED),
        .o_timeout (w_timeout)
    );

    assign bus.ctrl_pc_o        = w_ctrl[0];
    assign bus.ctrl_if_id_o     = w_ctrl[1];
    assign bus.ctrl_id_ex_o     = w_ctrl[2];
    assign bus.ctrl_ex_mem_o    = w_ctrl[3];
    assign bus.ctrl_mem_wb_o    = w_ctrl[4];
    assign bus.redirect_valid_o = ~rst & w_apply;
    assign bus.redirect_pc_o    = (~rst & w_apply) ? w_tgt : '0;
    assign bus.drain_done_o     = ~rst & w_done;
    assign bus.stall_timeout_o  = ~rst & w_timeout;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scenarios plus random traffic against a behavioural model
module tb_pipe_hazard_ctrl;
    localparam int AW = 64;
    localparam int DC = 3;
    localparam int TO = 1023;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.ADDR_W(AW)) hz();

    pipe_hazard_ctrl #(.ADDR_W(AW), .DRAIN_CYC(DC), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (hz)
    );

    int n_chk = 0;
    int n_err = 0;

    // model state: drain in progress, clean drain cycles seen, pending redirect, stall run length
    bit          m_drain, m_pend;
    int          m_dcnt, m_wd;
    logic [63:0] m_ppc;

    logic [9:0]  o_ctrl;
    logic        o_rv, o_done, o_to;
    logic [63:0] o_rpc;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic sample();
        o_ctrl = {hz.ctrl_pc_o, hz.ctrl_if_id_o, hz.ctrl_id_ex_o, hz.ctrl_ex_mem_o, hz.ctrl_mem_wb_o};
        o_rv   = hz.redirect_valid_o;
        o_rpc  = hz.redirect_pc_o;
        o_done = hz.drain_done_o;
        o_to   = hz.stall_timeout_o;
    endtask

    // one clock: drive, check all outputs against the model, advance the model
    task automatic step(input bit a_mem = 0, input bit a_ex = 0, input bit a_id = 0,
                        input bit a_if = 0, input bit a_rr = 0, input bit a_fen = 0,
                        input logic [63:0] a_pc = 64'h0);
        bit live, blocked, apply, done;
        int s;
        logic [9:0] e;
        logic [63:0] tgt;
        hz.mem_stall_req   = a_mem;
        hz.ex_stall_req    = a_ex;
        hz.id_stall_req    = a_id;
        hz.if_stall_req    = a_if;
        hz.ex_redirect_req = a_rr;
        hz.fence_req       = a_fen;
        hz.ex_redirect_pc  = a_pc;
        #1;
        sample();
        live    = a_rr || m_pend;
        blocked = a_mem || a_ex;
        apply   = live && !blocked;
        tgt     = m_pend ? m_ppc : a_pc;
        s = a_mem ? 4 : a_ex ? 3 : (m_drain || a_id) ? 2 : a_if ? 1 : 0;
        for (int r = 0; r < 5; r++)
            e[9-2*r -: 2] = apply ? ((r == 1 || r == 2) ? 2'b10 : 2'b00) :
                            (s == 0) ? 2'b00 : (r < s) ? 2'b01 : (r == s) ? 2'b10 : 2'b00;
        done = m_drain && !live && !blocked && (m_dcnt == DC - 1);
        chk("ctrl", 64'(o_ctrl), 64'(e));
        chk("redirect_valid", 64'(o_rv), 64'(apply));
        chk("redirect_pc", o_rpc, apply ? tgt : 64'h0);
        chk("drain_done", 64'(o_done), 64'(done));
        chk("stall_timeout", 64'(o_to), 64'(m_wd == TO));
        @(posedge clk);
        m_wd = (e[9:8] == 2'b01) ? ((m_wd < TO) ? m_wd + 1 : TO) : 0;
        if (apply) m_pend = 0;
        else if (live && !m_pend) begin
            m_pend = 1;
            m_ppc  = a_pc;
        end
        if (m_drain) begin
            if (apply || done) begin
                m_drain = 0;
                m_dcnt  = 0;
            end else if (!blocked && !live) m_dcnt++;
        end else if (a_fen && !live && !a_id && !blocked) begin
            m_drain = 1;
            m_dcnt  = 0;
        end
        @(negedge clk);
    endtask

    // async reset with busy inputs: outputs must drop at once, model state is discarded
    task automatic do_reset(input string tag);
        hz.mem_stall_req   = 1'b1;
        hz.ex_stall_req    = 1'b0;
        hz.id_stall_req    = 1'b1;
        hz.if_stall_req    = 1'b1;
        hz.ex_redirect_req = 1'b1;
        hz.fence_req       = 1'b1;
        hz.ex_redirect_pc  = '1;
        #2 rst = 1'b1;
        #1;
        sample();
        chk({tag, "_ctrl"}, 64'(o_ctrl), 64'h0);
        chk({tag, "_rv"}, 64'(o_rv), 64'h0);
        chk({tag, "_rpc"}, o_rpc, 64'h0);
        chk({tag, "_done"}, 64'(o_done), 64'h0);
        chk({tag, "_to"}, 64'(o_to), 64'h0);
        m_drain = 0; m_pend = 0; m_dcnt = 0; m_wd = 0; m_ppc = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        do_reset("rst0");

        step(0, 0, 1);
        chk("id_only", 64'(o_ctrl), 64'(10'b01_01_10_00_00));
        step(1, 0, 1);
        chk("mem_wins", 64'(o_ctrl), 64'(10'b01_01_01_01_10));

        step(1, 0, 0, 0, 1, 0, 64'h8000_0100);
        chk("redir_blk1", 64'(o_rv), 64'h0);
        step(1);
        chk("redir_blk2", 64'(o_rv), 64'h0);
        step(1);
        chk("redir_blk3", 64'(o_rv), 64'h0);
        step();
        chk("redir_apply", 64'(o_rv), 64'h1);
        chk("redir_target", o_rpc, 64'h8000_0100);
        chk("redir_ctrl", 64'(o_ctrl), 64'(10'b00_10_10_00_00));

        step(0, 0, 0, 0, 0, 1);
        step();
        chk("drain_c1", 64'(o_done), 64'h0);
        step(1);
        chk("drain_c2", 64'(o_done), 64'h0);
        step();
        chk("drain_c3", 64'(o_done), 64'h0);
        step();
        chk("drain_c4", 64'(o_done), 64'h1);
        step();
        chk("drain_after", 64'(o_done), 64'h0);

        step(0, 0, 0, 0, 0, 1);
        step();
        step(0, 0, 0, 0, 1, 0, 64'h1234);
        chk("abort_apply", 64'(o_rv), 64'h1);
        repeat (4) begin
            step();
            chk("abort_no_done", 64'(o_done), 64'h0);
        end

        repeat (TO) step(0, 0, 0, 1);
        chk("wd_before", 64'(o_to), 64'h0);
        step(0, 0, 0, 1);
        chk("wd_fire", 64'(o_to), 64'h1);
        step();
        step();
        chk("wd_clear", 64'(o_to), 64'h0);

        step(0, 0, 0, 0, 0, 1);
        step();
        step(1, 0, 0, 0, 1, 0, 64'hdead_beef);
        do_reset("rst_mid");
        step();
        chk("rst_pend_dropped", 64'(o_rv), 64'h0);
        step();
        chk("rst_drain_dropped", 64'(o_ctrl), 64'h0);

        for (int i = 0; i < 2500; i++)
            step($urandom_range(0, 99) < 12, $urandom_range(0, 99) < 10,
                 $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 10,
                 $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 20,
                 {$urandom, $urandom});

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
